// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared fetch/decode pipeline types and constants
package pipe_pkg;

    localparam int INSTR_W_DEF = 32;
    localparam int ADDR_W_DEF  = 64;

    // Bubble instruction decode inserts when nothing valid is presented (addi x0,x0,0)
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } pipe_state_e;

endpackage

// File: rtl/pipe_en_reg.sv
// rtl/pipe_en_reg.sv - parameter-width register vector with load enable and async active-low clear
module pipe_en_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] data_d;
    logic [W-1:0] data_q;

    always_comb begin
        data_d = en ? d : data_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign q = data_q;

endmodule

// File: rtl/if_id_skid_reg.sv
// rtl/if_id_skid_reg.sv - fetch-to-decode register with one-entry skid buffer and flush
// Optional IF_ID_STALL_CNT_EN adds a saturating stall_cycles counter output.
module if_id_skid_reg
    import pipe_pkg::*;
#(
    parameter int INSTR_W = INSTR_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [ADDR_W-1:0]  in_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
`ifdef IF_ID_STALL_CNT_EN
    output logic [15:0]        stall_cycles,
`endif
    output logic [ADDR_W-1:0]  out_pc
);

    localparam int EW = INSTR_W + ADDR_W;

    pipe_state_e   state_d, state_q;
    logic          in_ready_d, in_ready_q;
    logic          out_valid_d, out_valid_q;
    logic          main_en, skid_en;
    logic [EW-1:0] main_d, main_q, skid_q;

    always_comb begin
        state_d = state_q;
        main_en = 1'b0;
        skid_en = 1'b0;
        main_d  = {in_pc, in_instr};
        case (state_q)
            EMPTY: begin
                if (in_valid) begin
                    main_en = 1'b1;
                    state_d = FULL;
                end
            end
            FULL: begin
                if (out_ready && in_valid) begin
                    main_en = 1'b1;
                end else if (out_ready) begin
                    state_d = EMPTY;
                end else if (in_valid) begin
                    skid_en = 1'b1;
                    state_d = SKID;
                end
            end
            SKID: begin
                if (out_ready) begin
                    main_en = 1'b1;
                    main_d  = skid_q;
                    state_d = FULL;
                end
            end
            default: state_d = EMPTY;
        endcase
        // Flush only clears occupancy; stored data is left untouched.
        if (flush) begin
            state_d = EMPTY;
            main_en = 1'b0;
            skid_en = 1'b0;
        end
        in_ready_d  = (state_d != SKID);
        out_valid_d = (state_d != EMPTY);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    pipe_en_reg #(.W(EW)) u_main (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (main_en),
        .d       (main_d),
        .q       (main_q)
    );

    pipe_en_reg #(.W(EW)) u_skid (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (skid_en),
        .d       ({in_pc, in_instr}),
        .q       (skid_q)
    );

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_instr = main_q[INSTR_W-1:0];
    assign out_pc    = main_q[EW-1:INSTR_W];

`ifdef IF_ID_STALL_CNT_EN
    logic [15:0] stall_d, stall_q;

    always_comb begin
        stall_d = stall_q;
        if (out_valid_q && !out_ready && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_if_id_skid_reg.sv
// tb/tb_if_id_skid_reg.sv - self-checking bench for if_id_skid_reg against a queue model
module tb_if_id_skid_reg;

    localparam int IW = 32;
    localparam int AW = 64;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [IW-1:0] in_instr = '0;
    logic [AW-1:0] in_pc = '0;
    logic          in_ready;
    logic          out_valid;
    logic [IW-1:0] out_instr;
    logic [AW-1:0] out_pc;
`ifdef IF_ID_STALL_CNT_EN
    logic [15:0]   stall_cycles;
`endif

    always #5 clk = ~clk;

    if_id_skid_reg #(.INSTR_W(IW), .ADDR_W(AW)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_instr     (in_instr),
        .in_pc        (in_pc),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_instr    (out_instr),
`ifdef IF_ID_STALL_CNT_EN
        .stall_cycles (stall_cycles),
`endif
        .out_pc       (out_pc)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference model: a FIFO of at most two {pc,instr} entries.
    logic [95:0] mq[$];
    int unsigned m_stall = 0;

    initial begin
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                mq.delete();
                m_stall = 0;
            end else begin
                if (mq.size() != 0 && !out_ready && m_stall < 65535) m_stall++;
                if (flush) begin
                    mq.delete();
                end else begin
                    bit can_take;
                    can_take = (mq.size() < 2);
                    if (mq.size() != 0 && out_ready) void'(mq.pop_front());
                    if (in_valid && can_take) mq.push_back({in_pc, in_instr});
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("out_valid", out_valid, mq.size() != 0);
                check("in_ready", in_ready, mq.size() < 2);
                if (!reset_n) check("reset_data", {out_pc, out_instr}, 96'h0);
                else if (mq.size() != 0) check("out_data", {out_pc, out_instr}, mq[0]);
`ifdef IF_ID_STALL_CNT_EN
                check("stall_cycles", stall_cycles, m_stall);
`endif
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic v, input logic [IW-1:0] ins, input logic [AW-1:0] pc,
                       input logic ordy, input logic fl);
        in_valid  = v;
        in_instr  = ins;
        in_pc     = pc;
        out_ready = ordy;
        flush     = fl;
    endtask

    initial begin
        chk_en = 1'b1;
        tick();
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_pc", out_pc, 0);
        reset_n = 1'b1;
        tick();

        // Streaming: each accepted entry is visible right after its edge
        drv(1, 32'hA0, 64'h100, 1, 0); tick();
        check("stream0_pc", out_pc, 64'h100); check("stream0_in_ready", in_ready, 1);
        drv(1, 32'hA1, 64'h104, 1, 0); tick();
        check("stream1_pc", out_pc, 64'h104); check("stream1_instr", out_instr, 32'hA1);
        drv(1, 32'hA2, 64'h108, 1, 0); tick();
        check("stream2_pc", out_pc, 64'h108); check("stream2_in_ready", in_ready, 1);
        drv(0, 32'h0, 64'h0, 1, 0); tick();
        check("stream_drain", out_valid, 0);

        // Stall fill into skid, then ordered drain
        drv(1, 32'hB0, 64'h200, 0, 0); tick();
        drv(1, 32'hB1, 64'h204, 0, 0); tick();
        check("skid_in_ready", in_ready, 0); check("skid_pc", out_pc, 64'h200);
        drv(0, 32'h0, 64'h0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_hold_pc", out_pc, 64'h200);
        end
        drv(0, 32'h0, 64'h0, 1, 0); tick();
        check("drain_second_pc", out_pc, 64'h204); check("drain_in_ready", in_ready, 1);
        tick();
        check("drain_empty", out_valid, 0);

        // Flush while in SKID with a new input offered
        drv(1, 32'hC0, 64'h2F0, 0, 0); tick();
        drv(1, 32'hC1, 64'h2F4, 0, 0); tick();
        drv(1, 32'hC2, 64'h300, 1, 1); tick();
        check("flush_skid_valid", out_valid, 0); check("flush_skid_ready", in_ready, 1);
        drv(0, 32'h0, 64'h0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("flush_dropped", out_valid, 0);
        end

        // Flush with simultaneous output transfer and new input
        drv(1, 32'hD0, 64'h400, 0, 0); tick();
        drv(1, 32'hD1, 64'h404, 1, 1); tick();
        check("flush_full_valid", out_valid, 0); check("flush_full_ready", in_ready, 1);
        drv(0, 32'h0, 64'h0, 1, 0); tick();
        check("flush_full_empty", out_valid, 0);

        // Asynchronous reset while in SKID
        drv(1, 32'hE0, 64'h500, 0, 0); tick();
        drv(1, 32'hE1, 64'h504, 0, 0); tick();
        drv(0, 32'h0, 64'h0, 0, 0);
        reset_n = 1'b0;
        #1;
        check("async_rst_valid", out_valid, 0); check("async_rst_ready", in_ready, 1);
        check("async_rst_pc", out_pc, 0); check("async_rst_instr", out_instr, 0);
        tick();
        reset_n = 1'b1;
        drv(1, 32'hF0, 64'h600, 1, 0); tick();
        check("post_rst_first", out_pc, 64'h600);

        // Randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            drv($urandom_range(0, 3) != 0, $urandom, {$urandom, $urandom},
                $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);
            if (i == 700) reset_n = 1'b0;
            if (i == 702) reset_n = 1'b1;
            tick();
        end

`ifdef IF_ID_STALL_CNT_EN
        reset_n = 1'b0; tick(); reset_n = 1'b1;
        drv(1, 32'h11, 64'h700, 0, 0); tick();
        drv(0, 32'h0, 64'h0, 0, 0);
        for (int i = 0; i < 70000; i++) tick();
        check("stall_sat", stall_cycles, 16'hFFFF);
        drv(0, 32'h0, 64'h0, 0, 1); tick(); tick();
        drv(0, 32'h0, 64'h0, 0, 0); tick();
        check("stall_after_flush", stall_cycles, 16'hFFFF);
        reset_n = 1'b0; #1;
        check("stall_reset", stall_cycles, 16'h0);
        tick(); reset_n = 1'b1; tick();
`endif

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
